// File: rtl/nios_tdma_recv_data.sv
// Avalon-MM receive port for the TDMA link: queues incoming words in a FIFO and
// exposes DATA/STATUS/CONTROL/DROP_CNT registers plus a level interrupt to the Nios.
module nios_tdma_recv_data #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_port,
    input  logic              in_valid,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DCNT_W = 16;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DCNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              irq_en_q, irq_en_d;

    logic rd, wr, empty, full, pop, push, drop, flush, clr;

    // Bus decode and FIFO event qualification
    always_comb begin
        rd    = chipselect & ~read_n;
        wr    = chipselect & ~write_n;
        empty = (count_q == '0);
        full  = (count_q == CNT_W'(DEPTH));
        flush = wr & (address == 2'd2) & writedata[1];
        clr   = wr & (address == 2'd1) & writedata[18];
        pop   = rd & (address == 2'd0) & ~empty & ~flush;
        // A pop in the same cycle frees the slot the incoming word needs
        push  = in_valid & ~flush & (~full | pop);
        drop  = in_valid & ~flush & full & ~pop;
    end

    // Next-state for pointers, count and status registers
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        irq_en_d   = irq_en_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end

        if (clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {DCNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + DCNT_W'(1);
        end

        if (wr && address == 2'd2) irq_en_d = writedata[0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            irq_en_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            irq_en_q   <= irq_en_d;
        end
    end

    // Storage needs no reset: only slots below count are ever observable
    always_ff @(posedge clk) begin
        if (reset_n && push) mem_q[wr_ptr_q] <= in_port;
    end

    // Zero-latency read mux straight from registered state
    always_comb begin
        readdata = '0;
        case (address)
            2'd0: if (!empty) readdata = mem_q[rd_ptr_q];
            2'd1: begin
                readdata[CNT_W-1:0] = count_q;
                readdata[16]        = empty;
                readdata[17]        = full;
                readdata[18]        = overflow_q;
            end
            2'd2: readdata[0] = irq_en_q;
            default: readdata[DCNT_W-1:0] = drop_cnt_q;
        endcase
    end

    assign irq = irq_en_q & (~empty | overflow_q);

endmodule
